cla_seq_adder: RTL and testbench

Multi-cycle wide adder/subtractor controller for the ALU. It sequences a single shared 8-bit carry-lookahead adder slice across WIDTH-bit operands, one byte per clock, LSB first. The carry is registered between slices. Flags are accumulated and the result is presented on a valid/ready handshake. It sits between the ALU operand registers and the ALU result mux, so a wide add needs only one 8-bit CLA instance.

---
 rtl/alu_pkg.sv | 17 +
 rtl/cla_add8.sv | 46 ++++
 rtl/cla_seq_adder.sv | 116 +++++++++++
 tb/tb_cla_seq_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice width and the multi-cycle adder controller states.
package alu_pkg;

    localparam int unsigned SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slices needed to cover an operand of the given width.
    function automatic int unsigned slice_count(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_add8.sv
// Combinational 8-bit carry-lookahead adder slice.
module cla_add8
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of products over G/P terms, not a ripple chain.
    always_comb begin
        logic carry;
        logic term;
        c     = '0;
        carry = 1'b0;
        term  = 1'b0;
        c[0]  = ci;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            carry = ci;
            for (int j = 0; j <= i; j++) begin
                carry = carry & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                carry = carry | term;
            end
            c[i+1] = carry;
        end
    end

    assign s  = p ^ c[SLICE_W-1:0];
    assign co = c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract built from one shared 8-bit CLA slice,
// processed LSB byte first with the carry registered between slices.
module cla_seq_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int unsigned N     = slice_count(WIDTH);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic               zacc;
    logic [IDX_W-1:0]   idx;
    logic               last_slice;
    logic [SLICE_W-1:0] s_slice;
    logic               co_slice;

    // Operands shift right each BUSY cycle, so the active byte is always the low one.
    cla_add8 u_slice (
        .a  (a_r[SLICE_W-1:0]),
        .b  (b_r[SLICE_W-1:0]),
        .ci (carry_r),
        .s  (s_slice),
        .co (co_slice)
    );

    assign last_slice = (idx == IDX_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = BUSY;
            BUSY:    if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, one slice per BUSY cycle, hold in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum     <= '0;
            carry_r <= 1'b0;
            zacc    <= 1'b0;
            idx     <= '0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub | cin;
                        idx     <= '0;
                        zacc    <= 1'b1;
                    end
                end
                BUSY: begin
                    a_r     <= a_r >> SLICE_W;
                    b_r     <= b_r >> SLICE_W;
                    sum     <= (sum >> SLICE_W) | (WIDTH'(s_slice) << (WIDTH - SLICE_W));
                    carry_r <= co_slice;
                    zacc    <= zacc & ~|s_slice;
                    idx     <= last_slice ? '0 : idx + 1'b1;
                    if (last_slice) begin
                        flag_c <= co_slice;
                        flag_n <= s_slice[SLICE_W-1];
                        flag_v <= (a_r[SLICE_W-1] == b_r[SLICE_W-1]) &&
                                  (s_slice[SLICE_W-1] != a_r[SLICE_W-1]);
                        flag_z <= zacc & ~|s_slice;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder at WIDTH=32 and WIDTH=8.
module tb_cla_seq_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic        out_ready;
    logic        in_valid32;
    logic        in_valid8;

    logic        in_ready32, out_valid32, c32, v32, z32, n32;
    logic [31:0] sum32;
    logic        in_ready8, out_valid8, c8, v8, z8, n8;
    logic [7:0]  sum8;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid32), .out_ready(out_ready), .sum(sum32),
        .flag_c(c32), .flag_v(v32), .flag_z(z32), .flag_n(n32)
    );

    cla_seq_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .sub(sub), .cin(cin),
        .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8),
        .flag_c(c8), .flag_v(v8), .flag_z(z8), .flag_n(n8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic model, independent of the slice structure.
    function automatic res_t model(input bit w8, input logic [31:0] av, input logic [31:0] bv,
                                   input logic s, input logic ci);
        res_t        r;
        logic [32:0] full;
        logic [31:0] bb;
        logic        ma;
        logic        mb;
        bb = s ? ~bv : bv;
        if (w8) begin
            full  = 33'({1'b0, av[7:0]}) + 33'({1'b0, bb[7:0]}) + 33'(s ? 1'b1 : ci);
            r.sum = {24'h0, full[7:0]};
            r.c   = full[8];
            r.n   = full[7];
            ma    = av[7];
            mb    = bb[7];
        end else begin
            full  = {1'b0, av} + {1'b0, bb} + 33'(s ? 1'b1 : ci);
            r.sum = full[31:0];
            r.c   = full[32];
            r.n   = full[31];
            ma    = av[31];
            mb    = bb[31];
        end
        r.v = (ma == mb) && (r.n != ma);
        r.z = (r.sum == 32'h0);
        return r;
    endfunction

    function automatic res_t cur(input bit w8);
        res_t r;
        if (w8) begin
            r.sum = {24'h0, sum8}; r.c = c8;  r.v = v8;  r.z = z8;  r.n = n8;
        end else begin
            r.sum = sum32;         r.c = c32; r.v = v32; r.z = z32; r.n = n32;
        end
        return r;
    endfunction

    function automatic logic cur_ov(input bit w8);
        return w8 ? out_valid8 : out_valid32;
    endfunction

    function automatic logic cur_ir(input bit w8);
        return w8 ? in_ready8 : in_ready32;
    endfunction

    // One operation: drive, scramble inputs while busy, check latency, result, hold, release.
    task automatic run_op(input bit w8, input logic [31:0] av, input logic [31:0] bv,
                          input logic s, input logic ci, input int hold);
        res_t e;
        res_t o;
        int   cnt;
        @(negedge clk);
        chk("in_ready_idle", 64'(cur_ir(w8)), 64'(1));
        a = av; b = bv; sub = s; cin = ci; out_ready = 1'b0;
        if (w8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
        sb.push_back(model(w8, av, bv, s, ci));
        @(negedge clk);
        in_valid8 = 1'b0; in_valid32 = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        for (cnt = 1; cnt < 20; cnt++) begin
            if (cur_ov(w8)) break;
            chk("in_ready_busy", 64'(cur_ir(w8)), 64'(0));
            @(negedge clk);
            a = $urandom; b = $urandom;
        end
        chk("latency", 64'(cnt), w8 ? 64'(2) : 64'(5));
        if (!cur_ov(w8) || sb.size() == 0) return;
        e = sb.pop_front();
        o = cur(w8);
        chk("sum",    64'(o.sum), 64'(e.sum));
        chk("flag_c", 64'(o.c),   64'(e.c));
        chk("flag_v", 64'(o.v),   64'(e.v));
        chk("flag_z", 64'(o.z),   64'(e.z));
        chk("flag_n", 64'(o.n),   64'(e.n));
        chk("in_ready_done", 64'(cur_ir(w8)), 64'(0));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 64'(cur_ov(w8)), 64'(1));
            chk("hold_ready", 64'(cur_ir(w8)), 64'(0));
            chk("hold_result", 64'(cur(w8)), 64'(e));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 64'(cur_ov(w8)), 64'(0));
        chk("release_ready", 64'(cur_ir(w8)), 64'(1));
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
        in_valid32 = 1'b0; in_valid8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready32",  64'(in_ready32),  64'(1));
        chk("rst_out_valid32", 64'(out_valid32), 64'(0));
        chk("rst_result32",    64'(cur(1'b0)),   64'(0));
        chk("rst_in_ready8",   64'(in_ready8),   64'(1));
        chk("rst_result8",     64'(cur(1'b1)),   64'(0));
        rst = 1'b0;

        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 0);
        run_op(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 10);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 0);
        run_op(1'b0, 32'h0000_0009, 32'h0000_0009, 1'b1, 1'b1, 0);

        // Reset on the second BUSY cycle discards the operation.
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; cin = 1'b0; in_valid32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready",  64'(in_ready32),  64'(1));
        chk("midrst_out_valid", 64'(out_valid32), 64'(0));
        chk("midrst_result",    64'(cur(1'b0)),   64'(0));
        run_op(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 0);

        run_op(1'b1, 32'h0000_0080, 32'h0000_0080, 1'b0, 1'b1, 0);
        run_op(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 2);
        run_op(1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            run_op(1'(i % 2), $urandom, $urandom, 1'($urandom), 1'($urandom), i % 3);
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
